// File: rtl/popcount_pkg.sv
// Shared constants, FSM state type and parameter-width helper for the
// 3-bit popcount frame accumulator.
package popcount_pkg;

  localparam int DIN_W = 3;
  localparam int PC_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // True when a w-bit unsigned field can hold every value 0..max_val.
  function automatic bit width_ok(input int w, input int max_val);
    return w >= $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/popcount3.sv
// Combinational population count of a 3-bit word (result 0..3).
module popcount3
  import popcount_pkg::*;
(
  input  logic [DIN_W-1:0] din,
  output logic [PC_W-1:0]  dout
);

  assign dout = PC_W'(din[0]) + PC_W'(din[1]) + PC_W'(din[2]);

endmodule

// File: rtl/popcount3_frame_accum.sv
// Accumulates popcounts of a valid/ready word stream over frames of
// FRAME_LEN words (or fewer on in_last) and emits one registered total per frame.
module popcount3_frame_accum
  import popcount_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 5,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] din,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_words,
  output logic             out_short
);

  if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_frame_len_chk
    $error("FRAME_LEN must be in 1..255");
  end
  if (!width_ok(SUM_W, 3 * FRAME_LEN)) begin : g_sum_w_chk
    $error("SUM_W too narrow for 3*FRAME_LEN");
  end
  if (!width_ok(CNT_W, FRAME_LEN)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for FRAME_LEN");
  end

  state_e            state, state_next;
  logic [SUM_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [PC_W-1:0]   pc;
  logic [SUM_W-1:0]  acc_cur;
  logic [SUM_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;
  logic              close;

  popcount3 u_popcount3 (
    .din  (din),
    .dout (pc)
  );

  // A pending result that is being taken this cycle frees the stage immediately.
  assign in_ready = areset_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign close    = (cnt == CNT_W'(FRAME_LEN - 1)) || in_last;
  assign acc_cur  = (state == IDLE) ? '0 : acc;
  assign acc_sum  = acc_cur + SUM_W'(pc);
  assign cnt_inc  = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = close ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (close) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt_inc;
      end
    end
  end

  // A new close while the old result is being taken reloads without a bubble.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_words <= '0;
      out_short <= 1'b0;
    end else if (accept && close) begin
      out_valid <= 1'b1;
      out_sum   <= acc_sum;
      out_words <= cnt_inc;
      out_short <= (cnt_inc < CNT_W'(FRAME_LEN));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount3_frame_accum.sv
// Randomised self-checking bench for popcount3_frame_accum against a
// frame-level reference model built from word queues and $countones.
module tb_popcount3_frame_accum;

  localparam int FRAME_LEN = 8;
  localparam int SUM_W     = 5;
  localparam int CNT_W     = 4;

  logic             clk;
  logic             areset_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       din;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_words;
  logic             out_short;

  int checks = 0;
  int passes = 0;

  int cur[$];
  bit exp_valid = 0;
  int exp_sum   = 0;
  int exp_words = 0;
  bit exp_short = 0;

  popcount3_frame_accum #(
    .FRAME_LEN (FRAME_LEN),
    .SUM_W     (SUM_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_words (out_words),
    .out_short (out_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: collect accepted words, total them when the frame closes.
  task automatic model_step();
    bit rdy;
    rdy = !exp_valid || out_ready;
    if (in_valid && rdy) begin
      cur.push_back(int'(din));
      if (cur.size() == FRAME_LEN || in_last) begin
        exp_sum = 0;
        foreach (cur[i]) exp_sum += $countones(cur[i]);
        exp_words = cur.size();
        exp_short = (cur.size() < FRAME_LEN);
        exp_valid = 1'b1;
        cur.delete();
        return;
      end
    end
    if (out_ready) exp_valid = 1'b0;
  endtask

  task automatic model_reset();
    cur.delete();
    exp_valid = 1'b0;
  endtask

  task automatic drive(input bit v, input int d, input bit last);
    in_valid = v;
    din      = 3'(d);
    in_last  = last;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset_n  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_words !== '0 || out_short !== 1'b0)
      $display("[TB] FAIL reset_outputs got v=%0b s=%0d w=%0d sh=%0b want all zero",
               out_valid, out_sum, out_words, out_short);
    else passes++;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %0b want 0", in_ready);
    else passes++;
    areset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready got %0b want 1", in_ready);
    else passes++;
    model_reset();
  endtask

  task automatic test_full_frame();
    int words[8] = '{7, 0, 1, 2, 3, 4, 5, 6};
    out_ready = 1'b1;
    foreach (words[i]) begin
      drive(1'b1, words[i], 1'b0);
      cycle();
      checks++;
      if (out_valid !== exp_valid || (exp_valid && (out_sum !== exp_sum || out_words !== exp_words || out_short !== exp_short)))
        $display("[TB] FAIL full_frame w%0d got v=%0b s=%0d w=%0d sh=%0b want v=%0b s=%0d w=%0d sh=%0b",
                 i, out_valid, out_sum, out_words, out_short, exp_valid, exp_sum, exp_words, exp_short);
      else passes++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 12 || out_words !== 8 || out_short !== 1'b0)
      $display("[TB] FAIL full_frame_total got v=%0b s=%0d w=%0d sh=%0b want v=1 s=12 w=8 sh=0",
               out_valid, out_sum, out_words, out_short);
    else passes++;
    drive(1'b0, 0, 1'b0);
    cycle();
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL full_frame_one_cycle got v=%0b want 0", out_valid);
    else passes++;
  endtask

  task automatic test_max_sum();
    out_ready = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      drive(1'b1, 7, 1'b0);
      cycle();
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 24 || out_words !== 8 || out_short !== 1'b0)
      $display("[TB] FAIL max_sum got v=%0b s=%0d w=%0d sh=%0b want v=1 s=24 w=8 sh=0",
               out_valid, out_sum, out_words, out_short);
    else passes++;
    drive(1'b0, 0, 1'b0);
    cycle();
  endtask

  task automatic test_early_close();
    int words[3] = '{1, 3, 7};
    out_ready = 1'b1;
    foreach (words[i]) begin
      drive(1'b1, words[i], i == 2);
      cycle();
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6 || out_words !== 3 || out_short !== 1'b1)
      $display("[TB] FAIL early_close got v=%0b s=%0d w=%0d sh=%0b want v=1 s=6 w=3 sh=1",
               out_valid, out_sum, out_words, out_short);
    else passes++;
    for (int i = 0; i < FRAME_LEN; i++) begin
      drive(1'b1, 5, i == FRAME_LEN - 1);
      cycle();
      checks++;
      if (out_valid !== exp_valid || (exp_valid && (out_sum !== exp_sum || out_words !== exp_words || out_short !== exp_short)))
        $display("[TB] FAIL last_on_full w%0d got v=%0b s=%0d w=%0d sh=%0b want v=%0b s=%0d w=%0d sh=%0b",
                 i, out_valid, out_sum, out_words, out_short, exp_valid, exp_sum, exp_words, exp_short);
      else passes++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16 || out_words !== 8 || out_short !== 1'b0)
      $display("[TB] FAIL last_on_full_total got v=%0b s=%0d w=%0d sh=%0b want v=1 s=16 w=8 sh=0",
               out_valid, out_sum, out_words, out_short);
    else passes++;
    drive(1'b0, 0, 1'b0);
    cycle();
  endtask

  task automatic test_backpressure();
    int held_sum, held_words;
    bit held_short;
    out_ready = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      drive(1'b1, int'($urandom_range(0, 7)), 1'b0);
      cycle();
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== exp_sum || out_words !== exp_words || out_short !== exp_short)
      $display("[TB] FAIL bp_result got v=%0b s=%0d w=%0d sh=%0b want v=1 s=%0d w=%0d sh=%0b",
               out_valid, out_sum, out_words, out_short, exp_sum, exp_words, exp_short);
    else passes++;
    held_sum   = exp_sum;
    held_words = exp_words;
    held_short = exp_short;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, int'($urandom_range(0, 7)), 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready c%0d got %0b want 0", i, in_ready);
      else passes++;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== held_sum || out_words !== held_words || out_short !== held_short)
        $display("[TB] FAIL bp_hold c%0d got v=%0b s=%0d w=%0d sh=%0b want v=1 s=%0d w=%0d sh=%0b",
                 i, out_valid, out_sum, out_words, out_short, held_sum, held_words, held_short);
      else passes++;
    end
    out_ready = 1'b1;
    drive(1'b1, 3, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_in_ready got %0b want 1", in_ready);
    else passes++;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || cur.size() != 1)
      $display("[TB] FAIL bp_release got v=%0b model_words=%0d want v=0 model_words=1", out_valid, cur.size());
    else passes++;
    for (int i = 1; i < FRAME_LEN; i++) begin
      drive(1'b1, int'($urandom_range(0, 7)), 1'b0);
      cycle();
    end
    checks++;
    if (out_valid !== exp_valid || out_sum !== exp_sum || out_words !== exp_words || out_short !== exp_short)
      $display("[TB] FAIL bp_next_frame got v=%0b s=%0d w=%0d sh=%0b want v=%0b s=%0d w=%0d sh=%0b",
               out_valid, out_sum, out_words, out_short, exp_valid, exp_sum, exp_words, exp_short);
    else passes++;
    drive(1'b0, 0, 1'b0);
    cycle();
  endtask

  task automatic test_back_to_back();
    int results = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * FRAME_LEN; i++) begin
      drive(1'b1, int'($urandom_range(0, 7)), 1'b0);
      cycle();
      if (out_valid === 1'b1) results++;
      checks++;
      if (out_valid !== exp_valid || (exp_valid && (out_sum !== exp_sum || out_words !== exp_words || out_short !== exp_short)))
        $display("[TB] FAIL stream c%0d got v=%0b s=%0d w=%0d sh=%0b want v=%0b s=%0d w=%0d sh=%0b",
                 i, out_valid, out_sum, out_words, out_short, exp_valid, exp_sum, exp_words, exp_short);
      else passes++;
    end
    checks++;
    if (results != 4) $display("[TB] FAIL stream_result_count got %0d want 4", results);
    else passes++;
    drive(1'b0, 0, 1'b0);
    cycle();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0;
    drive(1'b1, 7, 1'b1);
    cycle();
    drive(1'b0, 0, 1'b0);
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL reset_drops_pending got v=%0b rdy=%0b want v=0 rdy=0", out_valid, in_ready);
    else passes++;
    #1 areset_n = 1'b1;
    model_reset();
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, int'($urandom_range(0, 7)), 1'b0);
      cycle();
    end
    drive(1'b0, 0, 1'b0);
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL reset_mid_async got v=%0b rdy=%0b want v=0 rdy=0", out_valid, in_ready);
    else passes++;
    #1 areset_n = 1'b1;
    model_reset();
    cycle();
    for (int i = 0; i < FRAME_LEN; i++) begin
      drive(1'b1, 1, 1'b0);
      cycle();
      checks++;
      if (out_valid !== exp_valid || (exp_valid && (out_sum !== exp_sum || out_words !== exp_words || out_short !== exp_short)))
        $display("[TB] FAIL reset_mid w%0d got v=%0b s=%0d w=%0d sh=%0b want v=%0b s=%0d w=%0d sh=%0b",
                 i, out_valid, out_sum, out_words, out_short, exp_valid, exp_sum, exp_words, exp_short);
      else passes++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8 || out_words !== 8 || out_short !== 1'b0)
      $display("[TB] FAIL reset_mid_total got v=%0b s=%0d w=%0d sh=%0b want v=1 s=8 w=8 sh=0",
               out_valid, out_sum, out_words, out_short);
    else passes++;
    drive(1'b0, 0, 1'b0);
    cycle();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_max_sum();
    test_early_close();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/popcount3_frame_accum.md
Name: popcount3_frame_accum

Overview:
Downstream consumer stage of the 3-bit population counter. It accepts a valid/ready stream of 3-bit words and popcounts each accepted word through an instance of the 3-bit counter. It accumulates the counts over a frame of FRAME_LEN words, or fewer if in_last arrives early. It then presents one registered frame total on a valid/ready output with full backpressure.

Parameters:
FRAME_LEN, 8, words per frame; legal range 1..255.
SUM_W, 5, width of out_sum; must satisfy 2**SUM_W > 3*FRAME_LEN (elaboration-time check).
CNT_W, 4, width of out_words; must satisfy 2**CNT_W > FRAME_LEN (elaboration-time check).

Ports:
clk  in  1  rising-edge clock
areset_n  in  1  asynchronous active-low reset
in_valid  in  1  din valid
in_ready  out  1  stage can accept din this cycle
din  in  3  input word
in_last  in  1  qualifies din as the final word of the current frame (early close)
out_valid  out  1  frame result valid
out_ready  in  1  downstream accepts result
out_sum  out  SUM_W  total set bits in the frame
out_words  out  CNT_W  number of words in the frame
out_short  out  1  frame was closed by in_last before FRAME_LEN words

Behaviour:
- Clock and reset: one clock, clk. Reset is areset_n, asynchronous and active-low.
- Reset values: out_valid=0, out_sum=0, out_words=0, out_short=0. Internal acc=0, cnt=0, FSM=IDLE.
- in_ready is combinational: in_ready = areset_n && (!out_valid || out_ready). It is 1 immediately after reset.
- Accept: a word is accepted when in_valid && in_ready. p = popcount(din), range 0..3, zero-extended to SUM_W.
- FSM states:
  - IDLE: cnt==0.
  - ACCUM: 0<cnt<FRAME_LEN.
- Transitions on accept, with close = (cnt==FRAME_LEN-1) || in_last:
  - No close: acc<=acc+p, cnt<=cnt+1, FSM stays in or enters ACCUM.
  - Close: out_sum<=acc+p, out_words<=cnt+1, out_short<=(cnt+1<FRAME_LEN), out_valid<=1, acc<=0, cnt<=0, FSM returns to IDLE.
- FRAME_LEN=1: every accepted word closes a frame.
- in_last when cnt==FRAME_LEN-1 gives a normal close with out_short=0.
- Latency: out_valid rises on the clock edge that accepts the closing word, so it is visible the cycle after the handshake.
- Output handshake:
  - out_valid && out_ready clears out_valid at the edge, unless a new close happens in the same cycle; in that case out_valid stays 1 and the new result is loaded.
  - out_sum, out_words and out_short hold stable while out_valid && !out_ready.
- Throughput: with out_ready held at 1, one word is accepted every cycle with no bubbles between frames.
- Backpressure: out_valid && !out_ready gives in_ready=0. No word is accepted, and acc/cnt are frozen.
- din and in_last are ignored when in_valid=0. The input side has no x-propagation requirement.
- No overflow is possible under the parameter checks. No saturation logic is needed.
- Reset mid-frame: the partial frame is discarded and a pending result is dropped. The first word after deassertion starts a new frame with cnt=0.
- Reset deassertion is synchronised externally; the block does not re-synchronise it.

Decomposition:
- Package popcount_pkg:
  - DIN_W=3 and PC_W=2 constants.
  - state_e typedef {IDLE, ACCUM}.
  - Helper function clog2-based width check used by the elaboration asserts.
- One sub-module: popcount3, the existing combinational counter (din[2:0] -> dout[1:0]), instantiated once on din.
- Accumulator, counter, FSM and output register stay in popcount3_frame_accum.

Test Plan:
- Full frame (FRAME_LEN=8, out_ready=1): din 7,0,1,2,3,4,5,6 back-to-back -> one result, out_sum=12, out_words=8, out_short=0, out_valid for exactly 1 cycle, one cycle after the 8th handshake.
- Maximum sum: 8 words of din=7 -> out_sum=24, out_words=8, out_short=0; no wrap.
- Early close: din 1,3,7 with in_last on the third word -> out_sum=6, out_words=3, out_short=1. Also din=5 with in_last on the 8th word -> out_short=0.
- Backpressure: complete a frame with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, out_* stable. Next frame's first word is accepted in the same cycle out_ready rises.
- Streaming: 4 consecutive 8-word frames with random din, in_valid=out_ready=1 -> 4 results 8 cycles apart. Each out_sum matches the scoreboard sum of per-word popcounts.
- Reset mid-frame: after 4 accepted words, pulse areset_n low for one cycle between edges -> out_valid=0 and in_ready=0 asynchronously. The next 8 words of din=1 produce out_sum=8, out_words=8.
